note2cnt_poly: RTL and testbench

//  Polyphonic successor of the single-voice note converter: maps MIDI notes for NCH channels to half-counter

---
 rtl/note2cnt_poly_pkg.sv | 30 +++
 rtl/note2cnt_poly_if.sv | 24 ++
 rtl/note2cnt_poly_slew.sv | 61 ++++++
 rtl/note2cnt_poly.sv | 115 +++++++++++
 tb/tb_note2cnt_poly.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note2cnt_poly_pkg.sv
// Shared constants for the polyphonic note-to-period converter: base-octave ROM,
// octave geometry and the conversion FSM state type.
package note2cnt_poly_pkg;

  localparam int NOTE_MIN_DEF = 21;
  localparam int OCT_SEMIS    = 12;
  localparam int MAX_SHIFT    = 8;

  // Half-periods of the lowest octave (A0 upward); higher octaves are right-shifts of these
  localparam logic [7:0] NOTE_ROM [0:11] = '{
    8'd248, 8'd234, 8'd221, 8'd209, 8'd197, 8'd186,
    8'd175, 8'd165, 8'd156, 8'd147, 8'd139, 8'd131
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOOK = 2'd2
  } state_t;

  function automatic logic [7:0] rom_entry(input logic [3:0] idx);
    logic [7:0] val;
    val = 8'd0;
    for (int i = 0; i < OCT_SEMIS; i++) begin
      if (idx == 4'(i)) val = NOTE_ROM[i];
    end
    return val;
  endfunction

endpackage

// File: rtl/note2cnt_poly_if.sv
// Note request channel from the MIDI decoder: valid/ready handshake carrying
// target channel and MIDI note number.
interface note2cnt_poly_if #(
  parameter int CHW = 2
);
  logic           note_valid_i;
  logic           note_ready_o;
  logic [CHW-1:0] note_ch_i;
  logic [7:0]     note_i;

  modport master (
    output note_valid_i,
    output note_ch_i,
    output note_i,
    input  note_ready_o
  );

  modport slave (
    input  note_valid_i,
    input  note_ch_i,
    input  note_i,
    output note_ready_o
  );
endinterface

// File: rtl/note2cnt_poly_slew.sv
// Per-channel target/current half-period registers. With NOTE_GLIDE_EN defined the
// current value slews toward the target on each tick; otherwise it tracks writes directly.
module note_glide_slew #(
  parameter int BW          = 16,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          wr_i,
  input  logic [BW-1:0] wdata_i,
  input  logic          tick_i,
  output logic [BW-1:0] target_o,
  output logic [BW-1:0] current_o
);

  logic [BW-1:0] r_tgt;
  logic [BW-1:0] r_cur;

`ifdef NOTE_GLIDE_EN
  // One glide step: |diff| >> GLIDE_SHIFT, at least 1, never past the target
  function automatic logic [BW-1:0] slew_step(input logic [BW-1:0] cur,
                                              input logic [BW-1:0] tgt);
    logic [BW-1:0] diff;
    logic [BW-1:0] step;
    diff = (cur > tgt) ? (cur - tgt) : (tgt - cur);
    step = diff >> GLIDE_SHIFT;
    if (step == '0) step = {{(BW-1){1'b0}}, 1'b1};
    if (step > diff) step = diff;
    return (cur > tgt) ? (cur - step) : (cur + step);
  endfunction

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_tgt <= '0;
      r_cur <= '0;
    end else if (wr_i) begin
      r_tgt <= wdata_i;
    end else if (tick_i && (r_cur != r_tgt)) begin
      r_cur <= slew_step(r_cur, r_tgt);
    end
  end
`else
  logic w_unused_tick;
  localparam int unused_glide_shift = GLIDE_SHIFT;
  assign w_unused_tick = tick_i;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_tgt <= '0;
      r_cur <= '0;
    end else if (wr_i) begin
      r_tgt <= wdata_i;
      r_cur <= wdata_i;
    end
  end
`endif

  assign target_o  = r_tgt;
  assign current_o = r_cur;

endmodule

// File: rtl/note2cnt_poly.sv
// Polyphonic MIDI note to oscillator half-period converter with one shared ROM and
// sequential octave divider. Optional portamento: define NOTE_GLIDE_EN.
module note2cnt_poly
  import note2cnt_poly_pkg::*;
#(
  parameter int BW          = 16,
  parameter int NCH         = 4,
  parameter int ROM_BW      = 8,
  parameter int NOTE_MIN    = NOTE_MIN_DEF,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  note2cnt_poly_if.slave      bus_if,
  input  logic                tick_i,
  output logic [NCH*BW-1:0]   period_o,
  output logic                busy_o
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW  = BW + MAX_SHIFT;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_rem;
  logic [4:0]      r_oct;
  logic [CHW-1:0]  r_ch;
  logic            r_busy;

  logic            w_idle;
  logic            w_accept;
  logic [7:0]      w_actual;
  logic [3:0]      w_shift;
  logic [ROM_BW-1:0] w_rom;
  logic [BW-1:0]   w_wdata;
  logic [NCH-1:0]  w_wr;
  logic [NCH-1:0]  w_neq;
  logic [BW-1:0]   w_cur [NCH];
  logic [BW-1:0]   w_tgt [NCH];

  assign w_idle              = (r_state == ST_IDLE);
  assign bus_if.note_ready_o = w_idle;
  assign w_accept            = bus_if.note_valid_i & w_idle;

  // Notes below the lowest supported key collapse onto it
  assign w_actual = (bus_if.note_i < 8'(NOTE_MIN)) ? 8'd0 : (bus_if.note_i - 8'(NOTE_MIN));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus_if.note_valid_i) w_state_nxt = ST_DIV;
      ST_DIV:  if (r_rem < 8'(OCT_SEMIS)) w_state_nxt = ST_LOOK;
      ST_LOOK: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Repeated subtraction: one octave per cycle, remainder ends as the ROM index
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_rem <= '0;
      r_oct <= '0;
      r_ch  <= '0;
    end else if (w_accept) begin
      r_rem <= w_actual;
      r_oct <= '0;
      r_ch  <= bus_if.note_ch_i;
    end else if ((r_state == ST_DIV) && (r_rem >= 8'(OCT_SEMIS))) begin
      r_rem <= r_rem - 8'(OCT_SEMIS);
      r_oct <= r_oct + 5'd1;
    end
  end

  assign w_shift = (r_oct >= 5'(MAX_SHIFT)) ? 4'd0 : 4'(MAX_SHIFT - int'(r_oct));
  assign w_rom   = ROM_BW'(rom_entry(r_rem[3:0]));
  assign w_wdata = BW'(WW'(w_rom) << w_shift);

  // Out-of-range channel numbers match no slot, so the request is simply dropped
  always_comb begin
    w_wr = '0;
    for (int c = 0; c < NCH; c++) begin
      w_wr[c] = (r_state == ST_LOOK) && (r_ch == CHW'(c));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    note_glide_slew #(
      .BW          (BW),
      .GLIDE_SHIFT (GLIDE_SHIFT)
    ) u_slew (
      .clk_i     (clk_i),
      .nrst_i    (nrst_i),
      .wr_i      (w_wr[g]),
      .wdata_i   (w_wdata),
      .tick_i    (tick_i),
      .target_o  (w_tgt[g]),
      .current_o (w_cur[g])
    );
    assign period_o[g*BW +: BW] = w_cur[g];
    assign w_neq[g]             = (w_cur[g] != w_tgt[g]);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_busy <= 1'b0;
    else         r_busy <= |w_neq;
  end

  assign busy_o = r_busy;

endmodule

// File: tb/tb_note2cnt_poly.sv
// Bench for note2cnt_poly: directed and random note requests checked every cycle
// against a behavioural latency/period model.
module tb_note2cnt_poly;

  localparam int BW   = 16;
  localparam int NCH  = 4;
  localparam int NCH2 = 3;
`ifdef NOTE_GLIDE_EN
  localparam bit GLIDE = 1'b1;
`else
  localparam bit GLIDE = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst;
  logic tick;
  logic tick2;
  logic [NCH*BW-1:0]  period;
  logic               busy;
  logic [NCH2*BW-1:0] period2;
  logic               busy2;

  always #5 clk = ~clk;

  note2cnt_poly_if #(.CHW(2)) bus  ();
  note2cnt_poly_if #(.CHW(2)) bus2 ();

  note2cnt_poly #(.BW(BW), .NCH(NCH), .ROM_BW(8), .NOTE_MIN(21), .GLIDE_SHIFT(4)) dut (
    .clk_i(clk), .nrst_i(nrst), .bus_if(bus), .tick_i(tick), .period_o(period), .busy_o(busy));

  note2cnt_poly #(.BW(BW), .NCH(NCH2), .ROM_BW(8), .NOTE_MIN(21), .GLIDE_SHIFT(4)) dut2 (
    .clk_i(clk), .nrst_i(nrst), .bus_if(bus2), .tick_i(tick2), .period_o(period2), .busy_o(busy2));

  int checks = 0;
  int errors = 0;

  int rom [12] = '{248, 234, 221, 209, 197, 186, 175, 165, 156, 147, 139, 131};
  int m_tgt [NCH];
  int m_cur [NCH];
  bit m_busy;
  bit m_rst;
  bit m_acc;
  int m_wcnt;
  int m_wch;
  int m_wval;

  function automatic int conv(input int n);
    int a;
    int o;
    int s;
    a = (n < 21) ? 0 : n - 21;
    o = a / 12;
    s = (o >= 8) ? 0 : 8 - o;
    return (rom[a % 12] << s) & 32'hFFFF;
  endfunction

  function automatic int slew(input int c, input int t);
    int d;
    int st;
    d  = (c > t) ? c - t : t - c;
    st = d / 16;
    if (st < 1) st = 1;
    if (st > d) st = d;
    return (c > t) ? c - st : c + st;
  endfunction

  function automatic bit settled();
    bit r;
    r = 1'b1;
    for (int c = 0; c < NCH; c++) if (m_cur[c] != m_tgt[c]) r = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 0;
      m_cur[c] = 0;
    end
    m_busy = 1'b0;
    m_wcnt = 0;
    m_acc  = 1'b0;
  endtask

  // Model of one rising edge: accept when idle, write q+2 edges after accept, glide on tick
  task automatic model_edge(input bit v, input int ch, input int n, input bit tk);
    bit nb;
    int wr_ch;
    int a;
    nb    = 1'b0;
    wr_ch = -1;
    m_acc = 1'b0;
    if (m_rst) begin
      model_clear();
      return;
    end
    nb = !settled();
    if (m_wcnt == 0) begin
      if (v) begin
        a      = (n < 21) ? 0 : n - 21;
        m_wcnt = a / 12 + 2;
        m_wch  = ch;
        m_wval = conv(n);
        m_acc  = 1'b1;
      end
    end else begin
      m_wcnt--;
      if (m_wcnt == 0) wr_ch = m_wch;
    end
    for (int c = 0; c < NCH; c++) begin
      if (c == wr_ch) begin
        m_tgt[c] = m_wval;
        if (!GLIDE) m_cur[c] = m_wval;
      end else if (GLIDE && tk && (m_cur[c] != m_tgt[c])) begin
        m_cur[c] = slew(m_cur[c], m_tgt[c]);
      end
    end
    m_busy = nb;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH*BW-1:0] ev;
    for (int c = 0; c < NCH; c++) ev[c*BW +: BW] = 16'(m_cur[c]);
    checks++;
    assert (bus.note_ready_o === (m_wcnt == 0)) else begin
      errors++;
      $error("FAIL ready got %b expected %b", bus.note_ready_o, (m_wcnt == 0));
    end
    checks++;
    assert (period === ev) else begin
      errors++;
      $error("FAIL period got %h expected %h", period, ev);
    end
    checks++;
    assert (busy === m_busy) else begin
      errors++;
      $error("FAIL busy got %b expected %b", busy, m_busy);
    end
  endtask

  task automatic cyc(input bit v, input int ch, input int n, input bit tk);
    bus.note_valid_i = v;
    bus.note_ch_i    = 2'(ch);
    bus.note_i       = 8'(n);
    tick             = tk;
    @(posedge clk);
    #1;
    model_edge(v, ch, n, tk);
    check_all();
  endtask

  task automatic send(input int ch, input int n);
    int g;
    g = 0;
    cyc(1'b1, ch, n, 1'b0);
    while (!m_acc && g < 60) begin
      cyc(1'b1, ch, n, 1'b0);
      g++;
    end
    bus.note_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_tick, output int k);
    k = 0;
    while (bus.note_ready_o !== 1'b1 && k < 100) begin
      cyc(1'b0, 0, 0, rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0);
      k++;
    end
  endtask

  task automatic reset_cycles(input int n);
    nrst  = 1'b0;
    m_rst = 1'b1;
    model_clear();
    #1;
    check_all();
    repeat (n) cyc(1'b0, 0, 0, 1'b0);
    nrst  = 1'b1;
    m_rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    int qch[$];
    int qn[$];
    nrst = 1'b0;
    tick = 1'b0;
    tick2 = 1'b0;
    bus.note_valid_i  = 1'b0;
    bus.note_ch_i     = '0;
    bus.note_i        = '0;
    bus2.note_valid_i = 1'b0;
    bus2.note_ch_i    = '0;
    bus2.note_i       = '0;
    m_rst = 1'b1;
    model_clear();

    // Reset state
    reset_cycles(3);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(bus.note_ready_o), 64'd1);

    // Lowest note, latency 2
    send(0, 21);
    wait_idle(1'b0, k);
    chk("lat_note21", 64'(k), 64'd2);
    chk("note21", 64'(period[15:0]), 64'd63488);

    send(1, 69);
    wait_idle(1'b0, k);
    chk("lat_note69", 64'(k), 64'd6);
    chk("note69", 64'(period[31:16]), 64'd3968);

    send(2, 10);
    wait_idle(1'b0, k);
    chk("note_clamped", 64'(period[47:32]), 64'd63488);

    send(3, 127);
    wait_idle(1'b0, k);
    chk("lat_note127", 64'(k), 64'd10);
    chk("note127", 64'(period[63:48]), 64'd139);

    // Out-of-range channel on the three-channel instance
    bus2.note_ch_i = 2'd2; bus2.note_i = 8'd69; bus2.note_valid_i = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    bus2.note_valid_i = 1'b0;
    repeat (7) cyc(1'b0, 0, 0, 1'b0);
    chk("d2_ch2", 64'(period2[47:32]), 64'd3968);
    bus2.note_ch_i = 2'd3; bus2.note_i = 8'd21; bus2.note_valid_i = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    bus2.note_valid_i = 1'b0;
    chk("d2_drop_accept", 64'(bus2.note_ready_o), 64'd0);
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    chk("d2_drop_period", 64'(period2), {16'd0, 16'd3968, 32'd0});
    chk("d2_drop_ready", 64'(bus2.note_ready_o), 64'd1);
    chk("d2_busy", 64'(busy2), 64'd0);

`ifdef NOTE_GLIDE_EN
    g = 0;
    while (!settled() && g < 3000) begin
      cyc(1'b0, 0, 0, 1'b1);
      g++;
    end
    repeat (2) cyc(1'b0, 0, 0, 1'b0);
    send(1, 81);
    wait_idle(1'b0, k);
    chk("gl_hold", 64'(period[31:16]), 64'd3968);
    cyc(1'b0, 0, 0, 1'b1);
    chk("gl_first", 64'(period[31:16]), 64'd3844);
    g = 0;
    while (period[31:16] !== 16'd1984 && g < 300) begin
      cyc(1'b0, 0, 0, 1'b1);
      g++;
    end
    chk("gl_end", 64'(period[31:16]), 64'd1984);
    repeat (2) cyc(1'b0, 0, 0, 1'b0);
    chk("gl_busy_fall", 64'(busy), 64'd0);
`endif

    // Valid held high: one accept per idle period
    repeat (20) cyc(1'b1, 0, 33, 1'b0);
    bus.note_valid_i = 1'b0;
    wait_idle(1'b0, k);
    chk("held_note33", 64'(period[15:0]), 64'(conv(33)));

    // Back-to-back queue serviced in order
    for (int i = 0; i < 6; i++) begin
      qch.push_back($urandom_range(0, NCH - 1));
      qn.push_back($urandom_range(0, 127));
    end
    g = 0;
    while (qch.size() > 0 && g < 500) begin
      cyc(1'b1, qch[0], qn[0], 1'($urandom_range(0, 1)));
      if (m_acc) begin
        void'(qch.pop_front());
        void'(qn.pop_front());
      end
      g++;
    end
    bus.note_valid_i = 1'b0;
    wait_idle(1'b1, k);

    // Random requests with random gaps and ticks
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 0, 0, 1'($urandom_range(0, 1)));
      send($urandom_range(0, NCH - 1), $urandom_range(0, 255));
      wait_idle(1'b1, k);
    end
    repeat (5) cyc(1'b0, 0, 0, 1'($urandom_range(0, 1)));

    // Reset in the middle of a conversion
    send(0, 69);
    repeat (2) cyc(1'b0, 0, 0, 1'b0);
    reset_cycles(2);
    repeat (8) cyc(1'b0, 0, 0, 1'b0);
    chk("abort_period", 64'(period), 64'd0);
    chk("abort_ready", 64'(bus.note_ready_o), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
